exhaustive_vector_gen: RTL and testbench
========================================

Name: exhaustive_vector_gen

Overview:
Synthesizable, parametrised successor to our exhaustive truth-table stimulus bench. It walks every combination of N_IN input bits in binary or Gray order, holding each vector HOLD cycles. It samples the DUT response at the end of each hold window and compacts the responses into a MISR signature. It sits between a small combinational DUT and a host or checker, giving on-chip pass/fail by signature compare.

Parameters:
N_IN, 3, number of DUT input bits; legal range 1..16
N_OUT, 1, number of DUT response bits; legal range 1..SIG_W
HOLD, 20, clock cycles each vector is held; must be >= 1
SIG_W, 16, MISR width
POLY, 16'h1021, Galois feedback polynomial; low SIG_W bits are used
SIG_SEED, 0, signature value loaded at reset and on each start

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a sweep; honoured only when not busy
abort  input  1  stop the sweep; returns the block to IDLE
mode  input  1  0 = binary order, 1 = Gray order; sampled when start is accepted
resp_in  input  N_OUT  DUT response to vec_out
vec_out  output  N_IN  registered stimulus driven to the DUT
vec_valid  output  1  high while vec_out carries a sweep vector
vec_idx  output  N_IN  ordinal of the current vector (0..2^N_IN-1)
busy  output  1  sweep in progress
done  output  1  level; high after a completed sweep until the next accepted start
signature  output  SIG_W  MISR contents

Behaviour:
- Reset (async, rst_n=0) forces: state IDLE; vec_out=0; vec_valid=0; vec_idx=0; busy=0; done=0; signature=SIG_SEED. Counters are cleared.
- States: IDLE, DRIVE, DONE.
- IDLE, start=1 and abort=0: at the next edge:
  - busy=1, vec_valid=1, done=0
  - vec_idx=0, vec_out=enc(0)
  - signature=SIG_SEED, hold_cnt=0
  - mode is latched; go to DRIVE.
- enc(i) = i in binary mode; enc(i) = i ^ (i>>1) in Gray mode.
- DRIVE, each cycle: hold_cnt increments.
- DRIVE, edge where hold_cnt==HOLD-1:
  - resp_in is sampled and sig_next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(resp_in).
  - If vec_idx < 2^N_IN-1: vec_idx++, vec_out=enc(vec_idx+1), hold_cnt=0.
  - Else: go to DONE with busy=0, vec_valid=0, done=1. vec_out holds its last value.
- Each vector is presented for exactly HOLD cycles. A full sweep keeps busy high for 2^N_IN*HOLD cycles. The last MISR update and the DONE entry happen on the same edge.
- DONE: done stays high and signature is stable. start behaves as in IDLE (restart). abort moves to IDLE and clears done.
- abort in DRIVE: next edge goes to IDLE with busy=0, vec_valid=0, done=0. signature keeps its partial value; vec_out and vec_idx hold.
- abort and start in the same cycle: abort wins and start is ignored.
- start while busy is ignored.
- mode changes during a sweep have no effect.
- vec_idx wrap: none. The terminal index ends the sweep; there is no modular wrap.
- HOLD=1: a new vector every cycle, with a MISR update every cycle.
- Reset asserted mid-sweep aborts immediately to reset values. No partial signature survives.

Decomposition:
- Package evg_pkg:
  - state enum (IDLE, DRIVE, DONE)
  - MODE_BIN=1'b0 and MODE_GRAY=1'b0+1 constants
  - function bin2gray
- One sub-module: evg_misr. It has parameters SIG_W, N_IN_W (= N_OUT), POLY and SIG_SEED, and ports clk, rst_n, clear, en, din and sig. Top-level sequencing (FSM, hold counter, index counter) stays in exhaustive_vector_gen.

Test Plan:
1. Sweep of a 3-input AND: N_IN=3, N_OUT=1, HOLD=2, mode=0, resp_in=&vec_out, pulse start.
   Required: vec_out steps 0..7, each held 2 cycles; busy high 16 cycles; then done=1, signature=16'h0001.
2. Constant response: resp_in tied 1, same config.
   Required: signature=16'h00FF at done.
3. Gray order: mode=1, HOLD=1.
   Required: vec_out sequence 0,1,3,2,6,7,5,4, each differing from the previous in exactly one bit; vec_idx 0..7; done after 8 cycles.
4. Mid-sweep abort and restart:
   - Assert abort at vec_idx=3. Required: next cycle busy=0, vec_valid=0, done=0, vec_out=3 held.
   - Then start with resp_in tied 1. Required: signature reseeds to 0 and ends at 16'h00FF.
5. Simultaneous and ignored requests:
   - start and abort together in IDLE. Required: stays IDLE.
   - start pulsed while busy. Required: sweep unaffected, total length still 2^N_IN*HOLD.
6. Reset mid-sweep: drop rst_n asynchronously between clock edges during DRIVE.
   Required: all outputs go to reset values immediately, signature=SIG_SEED; after rst_n release the block idles until start.

Source files
------------

// File: rtl/evg_pkg.sv
// evg_pkg: shared types and helpers for the exhaustive vector generator.
//   state_t   - sequencer states (IDLE, DRIVE, DONE)
//   MODE_BIN  - binary sweep order
//   MODE_GRAY - Gray-code sweep order
//   bin2gray  - binary to reflected Gray code (up to 16 bits)
package evg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b0 + 1'b1;

  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/exhaustive_vector_gen_if.sv
// exhaustive_vector_gen_if: control, stimulus and response bundle of the
// exhaustive vector generator.
//   start, abort, mode   - sweep control from the host
//   resp_in              - response of the combinational DUT to vec_out
//   vec_out, vec_idx     - current stimulus vector and its ordinal
//   vec_valid            - qualifies vec_out/vec_idx
//   busy, done           - sweep status
//   signature            - MISR contents
// Handshake: vec_valid is high exactly while vec_out/vec_idx carry a sweep
// vector. There is no ready: the DUT is combinational and has no say in
// pacing; its response is sampled on the last cycle of each hold window.
// start is a one-cycle request accepted only in IDLE/DONE; abort always wins.
// Modports: master = generator side, slave = host/DUT side.
interface exhaustive_vector_gen_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int SIG_W = 16
);
  logic             start;
  logic             abort;
  logic             mode;
  logic [N_OUT-1:0] resp_in;
  logic [N_IN-1:0]  vec_out;
  logic             vec_valid;
  logic [N_IN-1:0]  vec_idx;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;

  modport master (
    input  start, abort, mode, resp_in,
    output vec_out, vec_valid, vec_idx, busy, done, signature
  );

  modport slave (
    output start, abort, mode, resp_in,
    input  vec_out, vec_valid, vec_idx, busy, done, signature
  );
endinterface

// File: rtl/evg_misr.sv
// evg_misr: Galois-style multiple-input signature register.
//   clk, rst_n - clock and async active-low reset (loads SIG_SEED)
//   clear      - synchronous reload of SIG_SEED (wins over en)
//   en         - fold din into the signature this edge
//   din        - response word, zero-extended to SIG_W
//   sig        - current signature
module evg_misr #(
  parameter int               SIG_W    = 16,
  parameter int               N_IN_W   = 1,
  parameter logic [SIG_W-1:0] POLY     = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [N_IN_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] fb;
  logic [SIG_W-1:0] din_ext;
  logic [SIG_W-1:0] sig_next;

  always_comb begin
    fb       = sig[SIG_W-1] ? POLY : '0;
    din_ext  = SIG_W'(din);
    sig_next = (sig << 1) ^ fb ^ din_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SIG_SEED;
    end else if (clear) begin
      sig <= SIG_SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/exhaustive_vector_gen.sv
// exhaustive_vector_gen: walks all 2^N_IN input vectors in binary or Gray
// order, holding each for HOLD cycles, and compacts the DUT response sampled
// at the end of every hold window into a MISR signature.
//   clk, rst_n - clock and async active-low reset
//   bus        - exhaustive_vector_gen_if master modport (control, stimulus,
//                response, status, signature)
//   state_dbg  - current sequencer state, for observation only
module exhaustive_vector_gen
  import evg_pkg::*;
#(
  parameter int               N_IN     = 3,
  parameter int               N_OUT    = 1,
  parameter int               HOLD     = 20,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  exhaustive_vector_gen_if.master bus,
  output state_t                  state_dbg
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [N_IN-1:0]   IDX_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]   IDX_ONE   = N_IN'(1);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_IN-1:0]   vec_idx;
  logic [N_IN-1:0]   vec_out;
  logic              mode_q;
  logic              busy;
  logic              vec_valid;
  logic              done;
  logic              hold_end;
  logic              accept;
  logic [N_IN-1:0]   idx_next;

  function automatic logic [N_IN-1:0] enc(input logic [N_IN-1:0] i,
                                          input logic m);
    logic [15:0] g;
    g = bin2gray(16'(i));
    return (m == MODE_GRAY) ? g[N_IN-1:0] : i;
  endfunction

  always_comb begin
    hold_end = (state == DRIVE) && !bus.abort && (hold_cnt == HOLD_LAST);
    accept   = (state != DRIVE) && bus.start && !bus.abort;
    idx_next = vec_idx + IDX_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      vec_idx   <= '0;
      vec_out   <= '0;
      mode_q    <= MODE_BIN;
      busy      <= 1'b0;
      vec_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (bus.start) begin
            state     <= DRIVE;
            busy      <= 1'b1;
            vec_valid <= 1'b1;
            done      <= 1'b0;
            vec_idx   <= '0;
            vec_out   <= enc('0, bus.mode);
            hold_cnt  <= '0;
            mode_q    <= bus.mode;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            // Stimulus and partial signature are left as they were.
            state     <= IDLE;
            busy      <= 1'b0;
            vec_valid <= 1'b0;
            done      <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            if (vec_idx != IDX_LAST) begin
              vec_idx  <= idx_next;
              vec_out  <= enc(idx_next, mode_q);
              hold_cnt <= '0;
            end else begin
              // Terminal vector: no wrap, the sweep ends here.
              state     <= DONE;
              busy      <= 1'b0;
              vec_valid <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The MISR update for the last window shares its edge with DONE entry.
  evg_misr #(
    .SIG_W   (SIG_W),
    .N_IN_W  (N_OUT),
    .POLY    (POLY),
    .SIG_SEED(SIG_SEED)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .en   (hold_end),
    .din  (bus.resp_in),
    .sig  (bus.signature)
  );

  assign bus.vec_out   = vec_out;
  assign bus.vec_idx   = vec_idx;
  assign bus.vec_valid = vec_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign state_dbg     = state;

endmodule

// File: tb/tb_exhaustive_vector_gen.sv
module tb_exhaustive_vector_gen;
  import evg_pkg::*;

  localparam int N_IN  = 3;
  localparam int N_OUT = 1;
  localparam int SIG_W = 16;
  localparam int NV    = 1 << N_IN;
  localparam logic [15:0] POLY16 = 16'h1021;

  localparam int SEL_AND  = 0;
  localparam int SEL_ONE  = 1;
  localparam int SEL_ZERO = 2;
  localparam int SEL_OR   = 3;
  localparam int SEL_LUT  = 4;

  typedef struct {
    bit          mode;
    int          sel;
    logic [15:0] exp_sig;
  } vec_t;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int         sel_a = SEL_AND;
  logic [7:0] lut_a = 8'h00;

  exhaustive_vector_gen_if #(.N_IN(N_IN), .N_OUT(N_OUT), .SIG_W(SIG_W)) bif_a ();
  exhaustive_vector_gen_if #(.N_IN(N_IN), .N_OUT(N_OUT), .SIG_W(SIG_W)) bif_b ();
  state_t st_a;
  state_t st_b;

  exhaustive_vector_gen #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(2), .SIG_W(SIG_W))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bif_a), .state_dbg(st_a));
  exhaustive_vector_gen #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(1), .SIG_W(SIG_W))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bif_b), .state_dbg(st_b));

  // Response functions of the simulated combinational DUTs.
  function automatic logic resp_of(input int sel, input logic [2:0] v,
                                   input logic [7:0] lut);
    case (sel)
      SEL_AND:  return &v;
      SEL_ONE:  return 1'b1;
      SEL_ZERO: return 1'b0;
      SEL_OR:   return |v;
      default:  return lut[v];
    endcase
  endfunction

  always_comb bif_a.resp_in = resp_of(sel_a, bif_a.vec_out, lut_a);
  always_comb bif_b.resp_in = resp_of(SEL_AND, bif_b.vec_out, 8'h00);

  // Reference: visit the vectors in sweep order and fold each response.
  function automatic logic [15:0] model_sig(input bit m, input int sel,
                                            input logic [7:0] lut);
    logic [15:0] s;
    int v;
    s = 16'h0000;
    for (int i = 0; i < NV; i++) begin
      v = m ? (i ^ (i >> 1)) : i;
      s = {s[14:0], 1'b0} ^ (s[15] ? POLY16 : 16'h0000)
          ^ {15'd0, resp_of(sel, v[2:0], lut)};
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Full sweep on dut_a (HOLD=2), checking every cycle of the sweep.
  task automatic run_sweep(input bit m, input int sel, input logic [7:0] lut,
                           input logic [15:0] exp_sig, input bit pulse_mid);
    int idx;
    int ev;
    sel_a = sel;
    lut_a = lut;
    @(negedge clk);
    bif_a.start = 1'b1;
    bif_a.mode  = m;
    @(negedge clk);
    bif_a.start = 1'b0;
    bif_a.mode  = ~m;
    chk("seed", bif_a.signature, 32'h0);
    chk("valid_on", bif_a.vec_valid, 1);
    chk("done_clr", bif_a.done, 0);
    for (int k = 0; k < NV * 2; k++) begin
      idx = k / 2;
      ev  = m ? (idx ^ (idx >> 1)) : idx;
      chk("vec_out", bif_a.vec_out, ev);
      chk("vec_idx", bif_a.vec_idx, idx);
      chk("busy", bif_a.busy, 1);
      bif_a.start = (pulse_mid && k == 5);
      @(negedge clk);
    end
    bif_a.start = 1'b0;
    chk("end_busy", bif_a.busy, 0);
    chk("end_valid", bif_a.vec_valid, 0);
    chk("end_done", bif_a.done, 1);
    chk("end_state", st_a, DONE);
    chk("end_vec", bif_a.vec_out, m ? 4 : 7);
    chk("signature", bif_a.signature, exp_sig);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"}, bif_a.vec_out, 0);
    chk({tag, "_valid"}, bif_a.vec_valid, 0);
    chk({tag, "_idx"}, bif_a.vec_idx, 0);
    chk({tag, "_busy"}, bif_a.busy, 0);
    chk({tag, "_done"}, bif_a.done, 0);
    chk({tag, "_sig"}, bif_a.signature, 0);
    chk({tag, "_state"}, st_a, IDLE);
  endtask

  vec_t        tbl[6];
  logic [2:0]  gray_tab[8];
  logic [2:0]  prev_v;
  bit          rm;
  logic [7:0]  rl;

  initial begin
    tbl[0] = '{mode: 1'b0, sel: SEL_AND,  exp_sig: 16'h0001};
    tbl[1] = '{mode: 1'b0, sel: SEL_ONE,  exp_sig: 16'h00FF};
    tbl[2] = '{mode: 1'b1, sel: SEL_AND,  exp_sig: 16'h0004};
    tbl[3] = '{mode: 1'b1, sel: SEL_ONE,  exp_sig: 16'h00FF};
    tbl[4] = '{mode: 1'b0, sel: SEL_ZERO, exp_sig: 16'h0000};
    tbl[5] = '{mode: 1'b0, sel: SEL_OR,   exp_sig: 16'h007F};
    gray_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

    bif_a.start = 1'b0; bif_a.abort = 1'b0; bif_a.mode = 1'b0;
    bif_b.start = 1'b0; bif_b.abort = 1'b0; bif_b.mode = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_b_busy", bif_b.busy, 0);
    chk("rst_b_sig", bif_b.signature, 0);

    // Table-driven sweeps (binary/Gray, several response functions).
    for (int t = 0; t < 6; t++)
      run_sweep(tbl[t].mode, tbl[t].sel, 8'h00, tbl[t].exp_sig, 1'b0);

    // Gray order with HOLD=1 on dut_b.
    @(negedge clk);
    bif_b.start = 1'b1;
    bif_b.mode  = 1'b1;
    @(negedge clk);
    bif_b.start = 1'b0;
    prev_v = 3'd0;
    for (int k = 0; k < NV; k++) begin
      chk("g_vec", bif_b.vec_out, gray_tab[k]);
      chk("g_idx", bif_b.vec_idx, k);
      chk("g_busy", bif_b.busy, 1);
      if (k > 0) chk("g_onebit", $countones(bif_b.vec_out ^ prev_v), 1);
      prev_v = bif_b.vec_out;
      @(negedge clk);
    end
    chk("g_done", bif_b.done, 1);
    chk("g_busy_end", bif_b.busy, 0);
    chk("g_sig", bif_b.signature, 16'h0004);

    // Mid-sweep abort at vec_idx 3, then restart.
    sel_a = SEL_ONE;
    @(negedge clk);
    bif_a.start = 1'b1;
    bif_a.mode  = 1'b0;
    @(negedge clk);
    bif_a.start = 1'b0;
    for (int c = 0; c < 40 && bif_a.vec_idx != 3; c++) @(negedge clk);
    chk("ab_reach", bif_a.vec_idx, 3);
    bif_a.abort = 1'b1;
    @(negedge clk);
    bif_a.abort = 1'b0;
    chk("ab_busy", bif_a.busy, 0);
    chk("ab_valid", bif_a.vec_valid, 0);
    chk("ab_done", bif_a.done, 0);
    chk("ab_vec", bif_a.vec_out, 3);
    chk("ab_idx", bif_a.vec_idx, 3);
    chk("ab_sig", bif_a.signature, 16'h0007);
    chk("ab_state", st_a, IDLE);
    run_sweep(1'b0, SEL_ONE, 8'h00, 16'h00FF, 1'b0);

    // start+abort together: abort wins (from DONE, lands in IDLE).
    bif_a.start = 1'b1;
    bif_a.abort = 1'b1;
    @(negedge clk);
    bif_a.start = 1'b0;
    bif_a.abort = 1'b0;
    chk("sa_state", st_a, IDLE);
    chk("sa_busy", bif_a.busy, 0);
    chk("sa_done", bif_a.done, 0);
    @(negedge clk);
    chk("sa_hold", st_a, IDLE);

    // start pulsed while busy is ignored.
    run_sweep(1'b0, SEL_AND, 8'h00, 16'h0001, 1'b1);

    // Randomized sweeps against the reference model.
    for (int r = 0; r < 6; r++) begin
      rm = 1'($urandom_range(0, 1));
      rl = 8'($urandom);
      run_sweep(rm, SEL_LUT, rl, model_sig(rm, SEL_LUT, rl),
                1'($urandom_range(0, 1)));
    end

    // Async reset between edges in the middle of a sweep.
    sel_a = SEL_ONE;
    @(negedge clk);
    bif_a.start = 1'b1;
    @(negedge clk);
    bif_a.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rs_busy_pre", bif_a.busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rs_idle");
    run_sweep(1'b1, SEL_ONE, 8'h00, 16'h00FF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
